// File: rtl/key_schedule_collector.sv
// rtl/key_schedule_collector.sv - requests both key-schedule halves, assembles them, presents the full schedule
module key_schedule_collector #(
  parameter int KEY_WIDTH      = 256,
  parameter int HALF_WIDTH     = 1024,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [KEY_WIDTH-1:0]    key_in,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [KEY_WIDTH-1:0]    req_key,
  output logic [7:0]              req_flag,
  input  logic                    rsp_valid,
  input  logic [HALF_WIDTH-1:0]   rsp_data,
  output logic                    sched_valid,
  input  logic                    sched_ready,
  output logic [2*HALF_WIDTH-1:0] sched_data,
  output logic                    timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_LO, S_WAIT_LO, S_REQ_HI, S_WAIT_HI, S_OUT
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  wait_cnt;
  logic           in_wait, key_take, expired;

  assign in_wait  = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign key_take = (state == S_IDLE) && key_valid && key_ready;
  // A response arriving on the expiry cycle takes priority over the abort.
  assign expired  = TO_EN && in_wait && !rsp_valid && (wait_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (key_take) state_nxt = S_REQ_LO;
      S_REQ_LO:  if (req_ready) state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (rsp_valid) state_nxt = S_REQ_HI;
                 else if (expired) state_nxt = S_IDLE;
      S_REQ_HI:  if (req_ready) state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (rsp_valid) state_nxt = S_OUT;
                 else if (expired) state_nxt = S_IDLE;
      S_OUT:     if (sched_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_ready   <= 1'b0;
      req_valid   <= 1'b0;
      req_flag    <= 8'h00;
      req_key     <= '0;
      sched_valid <= 1'b0;
      sched_data  <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      key_ready   <= (state_nxt == S_IDLE);
      req_valid   <= (state_nxt == S_REQ_LO) || (state_nxt == S_REQ_HI);
      req_flag    <= (state_nxt == S_REQ_LO) ? 8'h01 :
                     (state_nxt == S_REQ_HI) ? 8'h02 : 8'h00;
      sched_valid <= (state_nxt == S_OUT);

      if (state_nxt != state) wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + CW'(1);

      if (key_take) begin
        req_key     <= key_in;
        timeout_err <= 1'b0;
      end else if (expired) begin
        timeout_err <= 1'b1;
      end

      if (state == S_WAIT_LO && rsp_valid)
        sched_data[HALF_WIDTH-1:0] <= rsp_data;
      else if (state == S_WAIT_HI && rsp_valid)
        sched_data[2*HALF_WIDTH-1:HALF_WIDTH] <= rsp_data;
      else if (expired)
        sched_data <= '0;
    end
  end

endmodule

// File: tb/tb_key_schedule_collector.sv
// tb/tb_key_schedule_collector.sv - self-checking bench for key_schedule_collector
module tb_key_schedule_collector;
  localparam int KW = 256;
  localparam int HW = 1024;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            key_valid = 1'b0;
  logic            key_ready;
  logic [KW-1:0]   key_in = '0;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic [KW-1:0]   req_key;
  logic [7:0]      req_flag;
  logic            rsp_valid = 1'b0;
  logic [HW-1:0]   rsp_data = '0;
  logic            sched_valid;
  logic            sched_ready = 1'b0;
  logic [2*HW-1:0] sched_data;
  logic            timeout_err;

  always #5 clock = ~clock;

  key_schedule_collector #(.KEY_WIDTH(KW), .HALF_WIDTH(HW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_flag(req_flag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_data(sched_data),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [KW-1:0] key;
    logic [HW-1:0] lo;
    logic [HW-1:0] hi;
    int d1, r1, d2, r2, sd;
    bit spur;
    bit exp_to;
    int exp_cyc;
  } txn_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [2*HW-1:0] act, input logic [2*HW-1:0] exp);
    int idx;
    n_total++;
    if (act === exp) n_pass++;
    else begin
      idx = 0;
      for (int i = 2*HW/64 - 1; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
      $display("FAIL %s: word %0d got %h expected %h", name, idx, act[idx*64 +: 64], exp[idx*64 +: 64]);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Reference: cycle numbers counted from the key-accept cycle (cycle 0).
  function automatic void model(input txn_t t, output bit to, output int cyc, output int endc);
    if (t.r1 >= TO) begin
      to = 1; cyc = 1 + (t.d1 + 1) + TO; endc = cyc;
    end else if (t.r2 >= TO) begin
      to = 1; cyc = 1 + (t.d1 + 1) + (t.r1 + 1) + (t.d2 + 1) + TO; endc = cyc;
    end else begin
      to = 0; cyc = 5 + t.d1 + t.r1 + t.d2 + t.r2; endc = cyc + t.sd + 1;
    end
  endfunction

  task automatic run_txn(input txn_t t, input bit exp_to, input int exp_cyc, input int exp_end,
                         input string tag);
    int ph, cnt, lat_obs, end_obs;
    bit req_bad, flag_bad, hold_bad;
    logic [2*HW-1:0] held;
    ph = 0; cnt = 0; lat_obs = -1; end_obs = -1;
    req_bad = 0; flag_bad = 0; hold_bad = 0; held = '0;
    key_in = t.key; key_valid = 1'b1; req_ready = 1'b0; sched_ready = 1'b0;
    rsp_valid = t.spur; rsp_data = ~t.lo;
    for (int w = 0; w < 20 && !key_ready; w++) step;
    chk({tag, " key_ready_idle"}, key_ready, 1);
    step;
    // Keep offering a different key to prove nothing is taken mid-operation.
    key_in = ~t.key;
    for (int c = 1; c < 200; c++) begin
      if (c == 1) chk({tag, " timeout_err_cleared"}, timeout_err, 0);
      if (key_ready) begin end_obs = c; break; end
      if (req_key !== t.key) req_bad = 1;
      if (sched_valid && lat_obs < 0) begin lat_obs = c; held = sched_data; end
      rsp_valid = 1'b0; req_ready = 1'b0; sched_ready = 1'b0;
      case (ph)
        0, 2: begin
          if (!req_valid || req_flag !== ((ph == 0) ? 8'h01 : 8'h02)) flag_bad = 1;
          if (t.spur) begin rsp_valid = 1'b1; rsp_data = ~t.hi; end
          if (cnt == ((ph == 0) ? t.d1 : t.d2)) begin req_ready = 1'b1; ph++; cnt = 0; end
          else cnt++;
        end
        1, 3: begin
          if (req_valid || req_flag !== 8'h00) flag_bad = 1;
          if (cnt == ((ph == 1) ? t.r1 : t.r2)) begin
            rsp_valid = 1'b1; rsp_data = (ph == 1) ? t.lo : t.hi; ph++; cnt = 0;
          end else cnt++;
        end
        default: begin
          if (!sched_valid || sched_data !== held) hold_bad = 1;
          if (cnt == t.sd) sched_ready = 1'b1;
          cnt++;
        end
      endcase
      step;
    end
    key_valid = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0; sched_ready = 1'b0;
    chk({tag, " timeout_err"}, timeout_err, exp_to);
    chk({tag, " end_cycle"}, end_obs, exp_end);
    if (exp_to) chk({tag, " sched_valid_seen"}, lat_obs >= 0, 0);
    else begin
      chk({tag, " sched_cycle"}, lat_obs, exp_cyc);
      chk_wide({tag, " sched_data"}, held, {t.hi, t.lo});
    end
    chk({tag, " req_key_stable"}, req_bad, 0);
    chk({tag, " req_flag_seq"}, flag_bad, 0);
    chk({tag, " sched_hold"}, hold_bad, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " key_ready"}, key_ready, 0);
    chk({tag, " req_valid"}, req_valid, 0);
    chk({tag, " req_flag"}, req_flag, 0);
    chk({tag, " sched_valid"}, sched_valid, 0);
    chk({tag, " timeout_err"}, timeout_err, 0);
    chk({tag, " req_key"}, req_key == '0, 1);
    chk({tag, " sched_data"}, sched_data == '0, 1);
  endtask

  function automatic txn_t mk(input logic [KW-1:0] k, input logic [HW-1:0] lo, input logic [HW-1:0] hi,
                              input int d1, input int r1, input int d2, input int r2, input int sd,
                              input bit spur, input bit exp_to, input int exp_cyc);
    txn_t t;
    t.key = k; t.lo = lo; t.hi = hi; t.d1 = d1; t.r1 = r1; t.d2 = d2; t.r2 = r2; t.sd = sd;
    t.spur = spur; t.exp_to = exp_to; t.exp_cyc = exp_cyc;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t tbl[7];
    txn_t t;
    logic [KW-1:0] k0;
    logic [HW-1:0] a_half, b_half;
    bit mto;
    int mcyc, mend;

    k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    a_half = {(HW/8){8'hAA}};
    b_half = {(HW/8){8'hBB}};
    tbl[0] = mk(k0, a_half, b_half, 0, 0, 0, 0, 0, 0, 0, 5);
    tbl[1] = mk(~k0, b_half, a_half, 10, 0, 0, 0, 0, 0, 0, 15);
    tbl[2] = mk(k0 ^ {KW/8{8'h5A}}, {(HW/8){8'h3C}}, {(HW/8){8'hC3}}, 0, 0, 0, 0, 20, 0, 0, 5);
    tbl[3] = mk(k0 + 1, a_half, b_half, 0, 0, 0, 16, 0, 0, 1, 20);
    tbl[4] = mk(k0 + 2, {(HW/8){8'h11}}, {(HW/8){8'h22}}, 0, 2, 0, 0, 0, 1, 0, 7);
    tbl[5] = mk(k0 + 3, {(HW/8){8'h33}}, {(HW/8){8'h44}}, 0, 15, 1, 0, 0, 0, 0, 21);
    tbl[6] = mk(k0 + 4, {(HW/8){8'h55}}, {(HW/8){8'h66}}, 3, 16, 0, 0, 0, 0, 1, 21);

    resetn = 1'b0;
    repeat (3) step;
    chk_zero_outputs("reset");
    resetn = 1'b1;
    chk("key_ready_before_first_edge", key_ready, 0);
    step;
    chk("key_ready_after_reset", key_ready, 1);

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i], tbl[i].exp_to, tbl[i].exp_cyc,
              tbl[i].exp_to ? tbl[i].exp_cyc : tbl[i].exp_cyc + tbl[i].sd + 1,
              $sformatf("vec%0d", i));

    // Reset pulse while waiting for the low half.
    key_in = ~k0; key_valid = 1'b1;
    for (int w = 0; w < 20 && !key_ready; w++) step;
    step;
    key_valid = 1'b0; req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    chk("rst_mid state_wait_lo", req_valid, 0);
    #2 resetn = 1'b0;
    #1 chk_zero_outputs("rst_mid");
    step;
    resetn = 1'b1;
    chk("rst_mid key_ready_low", key_ready, 0);
    step;
    chk("rst_mid key_ready_high", key_ready, 1);
    run_txn(tbl[0], 0, 5, 6, "after_reset");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < KW/32; i++) t.key[i*32 +: 32] = $urandom;
      for (int i = 0; i < HW/32; i++) begin
        t.lo[i*32 +: 32] = $urandom;
        t.hi[i*32 +: 32] = $urandom;
      end
      t.d1 = $urandom_range(0, 3);
      t.d2 = $urandom_range(0, 3);
      t.r1 = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      t.r2 = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      t.sd = $urandom_range(0, 3);
      t.spur = $urandom_range(0, 1);
      t.exp_to = 0; t.exp_cyc = 0;
      model(t, mto, mcyc, mend);
      run_txn(t, mto, mcyc, mend, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
